// File: rtl/inst_scheduler_pkg.sv
// Shared instruction-word decode for the scheduler and the instruction decoder:
// op classes, field positions and per-class resource requirements.
package pkg_inst_sched;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_MOVE  = 3'b011,
        OP_FETCH = 3'b100,
        OP_EXEC  = 3'b101,
        OP_RSVD  = 3'b110,
        OP_FENCE = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT_CU,
        ST_SETTLE
    } sched_state_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 29;
    localparam int EU_MSB = 28;
    localparam int EU_LSB = 24;

    function automatic logic needs_ldst(op_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic needs_move(op_t op);
        return (op == OP_MOVE);
    endfunction

    function automatic logic needs_eu(op_t op);
        return (op == OP_FETCH) || (op == OP_EXEC);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous in-order FIFO with level count; overflow policy belongs to the user.
module inst_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_q];

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/inst_scheduler.sv
// Host instruction queue and in-order dispatcher to the control unit.
// Define INST_SCHED_FENCE_EN to make FENCE drain all units before it retires.
module inst_scheduler #(
    parameter int DEPTH  = 8,
    parameter int EU_NUM = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              h2f_io,
    input  logic                     h2f_write,
    input  logic                     ovf_clr,
    output logic                     q_full,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic                     ovf,
    output logic                     sched_busy,
    output logic [31:0]              cu_inst,
    output logic                     cu_write,
    input  logic                     cu_running,
    input  logic                     ldst_busy,
    input  logic                     move_busy,
    input  logic [EU_NUM-1:0]        eu_busy
);
    import pkg_inst_sched::*;

    sched_state_t              state_q, state_d;
    logic                      rise_q, rise_d;
    logic                      cu_write_q, cu_write_d;
    logic [31:0]               cu_inst_q, cu_inst_d;
    logic                      ovf_q, ovf_d;
    logic                      pop;
    logic                      empty;
    logic [31:0]               head;
    op_t                       op;
    logic [EU_MSB-EU_LSB:0]    eu_idx;
    logic                      deps_ok;

    inst_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (h2f_write),
        .pop_i   (pop),
        .data_i  (h2f_io),
        .head_o  (head),
        .full_o  (q_full),
        .empty_o (empty),
        .level_o (q_level)
    );

    assign op     = op_t'(head[OP_MSB:OP_LSB]);
    assign eu_idx = head[EU_MSB:EU_LSB];

    assign deps_ok = !cu_running
                   && !(needs_ldst(op) && ldst_busy)
                   && !(needs_move(op) && move_busy)
                   && !(needs_eu(op)   && eu_busy[eu_idx]);

`ifdef INST_SCHED_FENCE_EN
    logic fence_ok;
    assign fence_ok = !cu_running && !ldst_busy && !move_busy && (eu_busy == '0);
`endif

    always_comb begin
        state_d    = state_q;
        rise_d     = rise_q;
        cu_write_d = 1'b0;
        cu_inst_d  = cu_inst_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (op == OP_NOP || op == OP_RSVD) begin
                        pop = 1'b1;
                    end
`ifdef INST_SCHED_FENCE_EN
                    else if (op == OP_FENCE) begin
                        pop = fence_ok;
                    end
`else
                    else if (op == OP_FENCE) begin
                        pop = 1'b1;
                    end
`endif
                    else if (deps_ok) begin
                        state_d    = ST_DISPATCH;
                        cu_write_d = 1'b1;
                        cu_inst_d  = head;
                    end
                end
            end
            ST_DISPATCH: begin
                pop     = 1'b1;
                rise_d  = cu_running;
                state_d = ST_WAIT_CU;
            end
            ST_WAIT_CU: begin
                // A full high-then-low cycle of cu_running marks the instruction as issued.
                if (cu_running) rise_d = 1'b1;
                if (rise_q && !cu_running) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An overflowing write wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (h2f_write && q_full && !pop) ovf_d = 1'b1;
        else if (ovf_clr)                ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rise_q     <= 1'b0;
            cu_write_q <= 1'b0;
            cu_inst_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rise_q     <= rise_d;
            cu_write_q <= cu_write_d;
            cu_inst_q  <= cu_inst_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cu_write   = cu_write_q;
    assign cu_inst    = cu_inst_q;
    assign ovf        = ovf_q;
    assign sched_busy = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_inst_scheduler.sv
// Self-checking bench for inst_scheduler: directed timing cases plus a randomized
// run scored against an in-order dispatch model. Honours INST_SCHED_FENCE_EN.
module tb_inst_scheduler;
    localparam int DEPTH  = 8;
    localparam int EU_NUM = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [31:0]            h2f_io = '0;
    logic                   h2f_write = 1'b0;
    logic                   ovf_clr = 1'b0;
    logic                   q_full;
    logic [$clog2(DEPTH):0] q_level;
    logic                   ovf;
    logic                   sched_busy;
    logic [31:0]            cu_inst;
    logic                   cu_write;
    logic                   cu_running;
    logic                   ldst_busy = 1'b0;
    logic                   move_busy = 1'b0;
    logic [EU_NUM-1:0]      eu_busy = '0;

    inst_scheduler #(.DEPTH(DEPTH), .EU_NUM(EU_NUM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h2f_io     (h2f_io),
        .h2f_write  (h2f_write),
        .ovf_clr    (ovf_clr),
        .q_full     (q_full),
        .q_level    (q_level),
        .ovf        (ovf),
        .sched_busy (sched_busy),
        .cu_inst    (cu_inst),
        .cu_write   (cu_write),
        .cu_running (cu_running),
        .ldst_busy  (ldst_busy),
        .move_busy  (move_busy),
        .eu_busy    (eu_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Control-unit model: isrunning high for run_len cycles after each strobe.
    int run_len = 3;
    int run_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           run_cnt <= 0;
        else if (cu_write)    run_cnt <= run_len;
        else if (run_cnt > 0) run_cnt <= run_cnt - 1;
    end
    assign cu_running = (run_cnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log plus randomized-phase scoreboard.
    int          strobe_cyc[$];
    logic [31:0] strobe_inst[$];
    logic [31:0] exp_q[$];
    bit          rnd_on = 0;
    int          last_strobe = -1000;
    logic        prev_cw = 1'b0, p_ldst = 1'b0, p_move = 1'b0, p_run = 1'b0;
    logic [31:0] p_eu = '0;
    logic [31:0] expw;

    function automatic logic dep_ok(logic [31:0] w, logic ld, logic mv, logic [31:0] eu, logic run);
        logic ok;
        case (w[31:29])
            3'd1, 3'd2: ok = !ld;
            3'd3:       ok = !mv;
            3'd4, 3'd5: ok = !eu[w[28:24]];
            default:    ok = 1'b0;
        endcase
        return ok && !run;
    endfunction

    function automatic bit is_skip(logic [31:0] w);
        return (w[31:29] == 3'd0) || (w[31:29] == 3'd6) || (w[31:29] == 3'd7);
    endfunction

    always @(negedge clk) begin
        if (cu_write) begin
            check_eq("cw_pulse", prev_cw, 0);
            strobe_cyc.push_back(cyc);
            strobe_inst.push_back(cu_inst);
            if (rnd_on) begin
                expw = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check_eq("sb_inst", cu_inst, expw);
                check_eq("sb_dep", dep_ok(cu_inst, p_ldst, p_move, p_eu, p_run), 1);
                check_eq("sb_space", (cyc - last_strobe) >= run_len + 4, 1);
                last_strobe = cyc;
            end
        end
        prev_cw = cu_write;
        p_ldst  = ldst_busy;
        p_move  = move_busy;
        p_eu    = eu_busy;
        p_run   = cu_running;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!sched_busy && !cu_running && q_level == 0) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("drain", done, 1);
        tick();
    endtask

    task automatic clear_log();
        strobe_cyc.delete();
        strobe_inst.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          nstr;
        logic        found;
        logic [31:0] w;
        logic [31:0] exp_seq[$];

        // Reset values
        #2;
        check_eq("rst_level", q_level, 0);
        check_eq("rst_full", q_full, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_cw", cu_write, 0);
        check_eq("rst_inst", cu_inst, 0);
        check_eq("rst_busy", sched_busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single LOAD, minimum latency
        run_len = 3;
        clear_log();
        t0 = cyc;
        h2f_io = 32'h2000_0010; h2f_write = 1'b1;
        tick();
        h2f_write = 1'b0;
        smp();
        check_eq("load_lvl1", q_level, 1);
        wait_idle(40);
        check_eq("load_nstr", strobe_cyc.size(), 1);
        check_eq("load_lat", strobe_cyc[0] - t0, 2);
        check_eq("load_inst", strobe_inst[0], 32'h2000_0010);
        check_eq("load_lvl0", q_level, 0);

        // Three back-to-back MOVEs with a 2-cycle isrunning pulse
        run_len = 2;
        clear_log();
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            h2f_io = 32'h6000_0001 + i; h2f_write = 1'b1;
            tick();
        end
        h2f_write = 1'b0;
        smp();
        check_eq("move_lvl", q_level, 2);
        wait_idle(80);
        check_eq("move_nstr", strobe_cyc.size(), 3);
        check_eq("move_lat", strobe_cyc[0] - t0, 2);
        for (int i = 0; i < 3; i++) check_eq("move_inst", strobe_inst[i], 32'h6000_0001 + i);
        for (int i = 1; i < 3; i++) check_eq("move_space", strobe_cyc[i] - strobe_cyc[i-1], 6);

        // EXEC to EU5 held off by eu_busy[5] for 20 cycles
        run_len = 3;
        clear_log();
        eu_busy = 32'h0000_0020;
        t0 = cyc;
        h2f_io = 32'hA500_0000; h2f_write = 1'b1;
        tick();
        h2f_write = 1'b0;
        repeat (19) tick();
        eu_busy = '0;
        wait_idle(60);
        check_eq("eu5_nstr", strobe_cyc.size(), 1);
        check_eq("eu5_lat", strobe_cyc[0] - t0, 21);
        check_eq("eu5_inst", strobe_inst[0], 32'hA500_0000);

        // Neighbouring EU busy does not stall
        clear_log();
        eu_busy = 32'h0000_0010;
        t0 = cyc;
        h2f_io = 32'hA500_0000; h2f_write = 1'b1;
        tick();
        h2f_write = 1'b0;
        wait_idle(40);
        eu_busy = '0;
        check_eq("eu4_nstr", strobe_cyc.size(), 1);
        check_eq("eu4_lat", strobe_cyc[0] - t0, 2);

        // Overflow, clear, push-with-pop while full, overflow beats clear
        clear_log();
        ldst_busy = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            h2f_io = 32'h2000_0100 + i; h2f_write = 1'b1;
            tick();
        end
        h2f_write = 1'b0;
        smp();
        check_eq("ovf_full", q_full, 1);
        check_eq("ovf_set", ovf, 1);
        check_eq("ovf_lvl", q_level, DEPTH);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        smp();
        check_eq("ovf_clr", ovf, 0);
        ldst_busy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cu_write) begin
                h2f_io = 32'h6000_00AA; h2f_write = 1'b1;
                ldst_busy = 1'b1;
                found = 1'b1;
                break;
            end
        end
        check_eq("full_strobe", found, 1);
        tick();
        h2f_write = 1'b0;
        smp();
        check_eq("pushpop_ovf", ovf, 0);
        check_eq("pushpop_lvl", q_level, DEPTH);
        tick();
        h2f_io = 32'h2000_0999; h2f_write = 1'b1; ovf_clr = 1'b1;
        tick();
        h2f_write = 1'b0; ovf_clr = 1'b0;
        smp();
        check_eq("ovf_vs_clr", ovf, 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        ldst_busy = 1'b0;
        wait_idle(300);
        check_eq("ovf_clr2", ovf, 0);
        exp_seq.delete();
        for (int i = 0; i < DEPTH; i++) exp_seq.push_back(32'h2000_0100 + i);
        exp_seq.push_back(32'h6000_00AA);
        check_eq("ovf_nstr", strobe_inst.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < strobe_inst.size(); i++)
            check_eq("ovf_order", strobe_inst[i], exp_seq[i]);

        // FENCE handling
        clear_log();
        move_busy = 1'b1;
        t0 = cyc;
        h2f_io = 32'hE000_0000; h2f_write = 1'b1;
        tick();
        h2f_write = 1'b0;
        smp();
        check_eq("fence_lvl1", q_level, 1);
        tick();
        smp();
`ifdef INST_SCHED_FENCE_EN
        check_eq("fence_hold", q_level, 1);
        repeat (7) tick();
        smp();
        check_eq("fence_hold9", q_level, 1);
        tick();
        move_busy = 1'b0;
        smp();
        check_eq("fence_hold10", q_level, 1);
        tick();
        smp();
        check_eq("fence_pop", q_level, 0);
`else
        check_eq("fence_pop", q_level, 0);
        move_busy = 1'b0;
`endif
        tick();
        move_busy = 1'b0;
        check_eq("fence_nostr", strobe_cyc.size(), 0);

        // Asynchronous reset mid-WAIT_CU with four words queued
        run_len = 3;
        clear_log();
        ldst_busy = 1'b1;
        h2f_io = 32'h6000_0005; h2f_write = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            h2f_io = 32'h2000_0200 + i;
            tick();
        end
        h2f_write = 1'b0;
        check_eq("pre_rst_inst", cu_inst, 32'h6000_0005);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_level", q_level, 0);
        check_eq("arst_full", q_full, 0);
        check_eq("arst_ovf", ovf, 0);
        check_eq("arst_cw", cu_write, 0);
        check_eq("arst_inst", cu_inst, 0);
        check_eq("arst_busy", sched_busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nstr = strobe_cyc.size();
        ldst_busy = 1'b0;
        repeat (20) tick();
        check_eq("arst_nostr", strobe_cyc.size(), nstr);
        check_eq("arst_lvl", q_level, 0);

        // Randomized traffic against the in-order dispatch model
        run_len = 3;
        exp_q.delete();
        last_strobe = -1000;
        rnd_on = 1;
        for (int k = 0; k < 1500; k++) begin
            ldst_busy = ($urandom % 4) == 0;
            move_busy = ($urandom % 4) == 0;
            eu_busy   = ($urandom % 2) ? (32'd1 << ($urandom % 32)) : 32'd0;
            if (($urandom % 3) == 0 && !q_full) begin
                w = {3'($urandom % 8), 29'($urandom)};
                h2f_io = w; h2f_write = 1'b1;
                if (!is_skip(w)) exp_q.push_back(w);
            end else begin
                h2f_write = 1'b0;
            end
            tick();
        end
        h2f_write = 1'b0;
        ldst_busy = 1'b0; move_busy = 1'b0; eu_busy = '0;
        wait_idle(500);
        rnd_on = 0;
        check_eq("rnd_left", exp_q.size(), 0);
        check_eq("rnd_ovf", ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
